// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store memory stage with a single-outstanding request/response port
module mem_stage #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  valid_i,
    input  logic                  is_load_i,
    input  logic                  is_store_i,
    input  logic                  is_byte_i,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [31:0]           alu_result_i,
    input  logic [31:0]           store_data_i,
    output logic                  stall_o,
    output logic                  err_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic                  req_we_o,
    output logic [31:0]           req_addr_o,
    output logic [3:0]            req_be_o,
    output logic [31:0]           req_wdata_o,
    input  logic                  resp_valid_i,
    input  logic [31:0]           resp_data_i,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wb_addr_o,
    output logic [31:0]           wb_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                  state, state_nxt;
    logic                    is_mem, misaligned, accept, accept_mem;
    logic [3:0]              be_nxt;
    logic [31:0]             wdata_nxt;
    logic [7:0]              load_byte;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [1:0]              off_q;
    logic                    byte_q;

    assign is_mem     = is_load_i | is_store_i;
    assign misaligned = !is_byte_i && (alu_result_i[1:0] != 2'b00);
    assign accept     = (state == S_IDLE) && valid_i;
    assign accept_mem = accept && is_mem && !misaligned;

    // Nothing can be accepted while reset is held, so the stall is forced low too.
    assign stall_o = n_reset & ((state != S_IDLE) | accept_mem);

    always_comb begin
        state_nxt = state;
        be_nxt    = 4'b1111;
        wdata_nxt = store_data_i;
        load_byte = resp_data_i[{off_q, 3'b000} +: 8];
        if (is_byte_i && is_store_i) begin
            be_nxt    = 4'b0001 << alu_result_i[1:0];
            wdata_nxt = {4{store_data_i[7:0]}};
        end
        case (state)
            S_IDLE: if (accept_mem) state_nxt = S_REQ;
            S_REQ:  if (req_ready_i) state_nxt = req_we_o ? S_IDLE : S_WAIT;
            S_WAIT: if (resp_valid_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            err_o       <= 1'b0;
            req_valid_o <= 1'b0;
            req_we_o    <= 1'b0;
            req_addr_o  <= '0;
            req_be_o    <= '0;
            req_wdata_o <= '0;
            wb_valid_o  <= 1'b0;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            rd_q        <= '0;
            off_q       <= '0;
            byte_q      <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    wb_valid_o <= wb_en_i;
                    wb_addr_o  <= rd_addr_i;
                    wb_data_o  <= alu_result_i;
                end else if (misaligned) begin
                    err_o <= 1'b1;
                end else begin
                    // A load with is_store_i also set is issued as a store.
                    req_valid_o <= 1'b1;
                    req_we_o    <= is_store_i;
                    req_addr_o  <= {alu_result_i[31:2], 2'b00};
                    req_be_o    <= be_nxt;
                    req_wdata_o <= wdata_nxt;
                    rd_q        <= rd_addr_i;
                    off_q       <= alu_result_i[1:0];
                    byte_q      <= is_byte_i;
                end
            end
            if (state == S_REQ && req_ready_i) begin
                req_valid_o <= 1'b0;
            end
            if (state == S_WAIT && resp_valid_i) begin
                wb_valid_o <= 1'b1;
                wb_addr_o  <= rd_q;
                wb_data_o  <= byte_q ? {24'h0, load_byte} : resp_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - vector table, directed corner sequences and randomized check of mem_stage
module tb_mem_stage;

    logic        clk, n_reset;
    logic        valid_i, is_load_i, is_store_i, is_byte_i, wb_en_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] alu_result_i, store_data_i;
    logic        stall_o, err_o, req_valid_o, req_ready_i, req_we_o;
    logic [31:0] req_addr_o, req_wdata_o;
    logic [3:0]  req_be_o;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_b [64];
    logic [31:0] dev_mem [16];

    mem_stage #(.REG_ADDR_W(5)) dut (
        .clk(clk), .n_reset(n_reset), .valid_i(valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .is_byte_i(is_byte_i), .wb_en_i(wb_en_i),
        .rd_addr_i(rd_addr_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .stall_o(stall_o), .err_o(err_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_we_o(req_we_o), .req_addr_o(req_addr_o), .req_be_o(req_be_o),
        .req_wdata_o(req_wdata_o), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st, byt, wb_en;
        logic [4:0]  rd;
        logic [31:0] addr, sdata;
        int          rdly, wdly;
        logic [31:0] resp;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_wb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0; wb_en_i = 1'b0;
        rd_addr_i = '0; alu_result_i = '0; store_data_i = '0;
        req_ready_i = 1'b0;
        resp_valid_i = 1'($urandom); resp_data_i = $urandom;
    endtask

    task automatic junk_inputs();
        valid_i = 1'b1; is_load_i = 1'($urandom); is_store_i = 1'($urandom);
        is_byte_i = 1'($urandom); wb_en_i = 1'b1; rd_addr_i = 5'($urandom);
        alu_result_i = $urandom; store_data_i = $urandom;
        resp_valid_i = 1'($urandom); resp_data_i = $urandom;
    endtask

    task automatic run_instr(input string tag, input logic ld, st, byt, wb_en, input logic [4:0] rd,
                             input logic [31:0] addr, sdata, input int rdly, wdly,
                             input logic [31:0] resp_word, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, exp_wb);
        logic mem, mis, is_ld;
        mem   = ld | st;
        mis   = mem && !byt && (addr[1:0] != 2'b00);
        is_ld = ld && !st;
        cyc_begin();
        valid_i = 1'b1; is_load_i = ld; is_store_i = st; is_byte_i = byt; wb_en_i = wb_en;
        rd_addr_i = rd; alu_result_i = addr; store_data_i = sdata;
        req_ready_i = 1'b0; resp_valid_i = 1'b0;
        cyc_sample();
        chk(tag, "stall_accept", stall_o, mem && !mis);
        if (!mem || mis) begin
            cyc_begin(); idle_inputs(); cyc_sample();
            chk(tag, "err", err_o, mis);
            chk(tag, "wb_valid", wb_valid_o, !mem && wb_en);
            if (!mem && wb_en) begin
                chk(tag, "wb_data", wb_data_o, exp_wb);
                chk(tag, "wb_addr", wb_addr_o, rd);
            end
            chk(tag, "req_valid", req_valid_o, 0);
            chk(tag, "stall", stall_o, 0);
            cyc_begin(); idle_inputs(); cyc_sample();
            chk(tag, "err_pulse", err_o, 0);
            chk(tag, "wb_pulse", wb_valid_o, 0);
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            cyc_begin(); junk_inputs(); req_ready_i = (i == rdly); cyc_sample();
            chk(tag, "req_valid", req_valid_o, 1);
            chk(tag, "req_we", req_we_o, st);
            chk(tag, "req_addr", req_addr_o, {addr[31:2], 2'b00});
            chk(tag, "req_be", req_be_o, exp_be);
            if (st) chk(tag, "req_wdata", req_wdata_o, exp_wdata);
            chk(tag, "stall_req", stall_o, 1);
            chk(tag, "wb_req", wb_valid_o, 0);
            if (i == rdly && req_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (req_be_o[b]) dev_mem[req_addr_o[5:2]][8*b +: 8] = req_wdata_o[8*b +: 8];
            end
        end
        if (is_ld) begin
            for (int i = 0; i <= wdly; i++) begin
                cyc_begin(); junk_inputs(); req_ready_i = 1'($urandom);
                resp_valid_i = (i == wdly);
                if (i == wdly) resp_data_i = resp_word;
                cyc_sample();
                chk(tag, "req_valid_wait", req_valid_o, 0);
                chk(tag, "stall_wait", stall_o, 1);
                chk(tag, "wb_wait", wb_valid_o, 0);
            end
        end
        cyc_begin(); idle_inputs(); cyc_sample();
        chk(tag, "stall_done", stall_o, 0);
        chk(tag, "req_valid_done", req_valid_o, 0);
        chk(tag, "wb_valid", wb_valid_o, is_ld);
        if (is_ld) begin
            chk(tag, "wb_data", wb_data_o, exp_wb);
            chk(tag, "wb_addr", wb_addr_o, rd);
        end
        cyc_begin(); idle_inputs(); cyc_sample();
        chk(tag, "wb_pulse", wb_valid_o, 0);
    endtask

    initial begin
        logic [31:0] a32, sd, exp_wb, rw, wd;
        logic [3:0]  eb;
        logic [4:0]  rd;
        logic        ld, st, byt, wbe;
        int          kind, a;

        vecs[0]  = '{0, 0, 0, 1, 5'd3,  32'h0000_0005, 32'h0,         0, 0, 32'h0,         4'hf, 32'h0,         32'h0000_0005};
        vecs[1]  = '{1, 0, 0, 0, 5'd7,  32'h0000_0100, 32'h0,         0, 0, 32'hDEAD_BEEF, 4'hf, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1, 0, 1, 0, 5'd8,  32'h0000_0102, 32'h0,         0, 0, 32'h1122_3344, 4'hf, 32'h0,         32'h0000_0022};
        vecs[3]  = '{0, 1, 1, 0, 5'd9,  32'h0000_0203, 32'h1234_56AB, 0, 0, 32'h0,         4'h8, 32'hABAB_ABAB, 32'h0};
        vecs[4]  = '{0, 1, 0, 0, 5'd10, 32'h0000_0300, 32'hCAFE_F00D, 3, 0, 32'h0,         4'hf, 32'hCAFE_F00D, 32'h0};
        vecs[5]  = '{1, 0, 0, 0, 5'd11, 32'h0000_0101, 32'h0,         0, 0, 32'h0,         4'hf, 32'h0,         32'h0};
        vecs[6]  = '{0, 0, 0, 0, 5'd12, 32'h1234_5678, 32'h0,         0, 0, 32'h0,         4'hf, 32'h0,         32'h0};
        vecs[7]  = '{1, 0, 0, 0, 5'd13, 32'h0000_0040, 32'h0,         2, 3, 32'h0BAD_F00D, 4'hf, 32'h0,         32'h0BAD_F00D};
        vecs[8]  = '{1, 1, 0, 0, 5'd14, 32'h0000_0404, 32'h0000_55AA, 1, 0, 32'h0,         4'hf, 32'h0000_55AA, 32'h0};
        vecs[9]  = '{0, 1, 1, 0, 5'd15, 32'h0000_0201, 32'h0000_007E, 0, 0, 32'h0,         4'h2, 32'h7E7E_7E7E, 32'h0};
        vecs[10] = '{1, 0, 1, 0, 5'd16, 32'h0000_0103, 32'h0,         1, 2, 32'hA1B2_C3D4, 4'hf, 32'h0,         32'h0000_00A1};
        vecs[11] = '{0, 1, 0, 0, 5'd17, 32'h0000_0302, 32'hFFFF_FFFF, 0, 0, 32'h0,         4'hf, 32'h0,         32'h0};

        n_reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cyc_begin(); junk_inputs(); req_ready_i = 1'($urandom); cyc_sample();
            chk("reset", "outs_or", |{stall_o, err_o, req_valid_o, req_we_o, req_addr_o, req_be_o,
                                      req_wdata_o, wb_valid_o, wb_addr_o, wb_data_o}, 0);
        end
        cyc_begin(); n_reset = 1'b1; idle_inputs(); resp_valid_i = 1'b0;

        foreach (vecs[i])
            run_instr($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].byt, vecs[i].wb_en,
                      vecs[i].rd, vecs[i].addr, vecs[i].sdata, vecs[i].rdly, vecs[i].wdly,
                      vecs[i].resp, vecs[i].exp_be, vecs[i].exp_wdata, vecs[i].exp_wb);

        // Back-to-back ALU results, one per cycle
        cyc_begin(); idle_inputs(); valid_i = 1'b1; wb_en_i = 1'b1; rd_addr_i = 5'd1; alu_result_i = 32'h11; cyc_sample();
        chk("b2b", "stall0", stall_o, 0);
        cyc_begin(); idle_inputs(); valid_i = 1'b1; wb_en_i = 1'b1; rd_addr_i = 5'd2; alu_result_i = 32'h22; cyc_sample();
        chk("b2b", "wb0_valid", wb_valid_o, 1);
        chk("b2b", "wb0_data", wb_data_o, 32'h11);
        chk("b2b", "wb0_addr", wb_addr_o, 5'd1);
        cyc_begin(); idle_inputs(); cyc_sample();
        chk("b2b", "wb1_valid", wb_valid_o, 1);
        chk("b2b", "wb1_data", wb_data_o, 32'h22);
        chk("b2b", "wb1_addr", wb_addr_o, 5'd2);
        cyc_begin(); idle_inputs(); cyc_sample();
        chk("b2b", "wb_end", wb_valid_o, 0);

        // Reset while the request is pending
        cyc_begin(); idle_inputs(); resp_valid_i = 1'b0; valid_i = 1'b1; is_load_i = 1'b1; alu_result_i = 32'h20; rd_addr_i = 5'd5; cyc_sample();
        cyc_begin(); idle_inputs(); resp_valid_i = 1'b0; cyc_sample();
        chk("rst_req", "req_valid_before", req_valid_o, 1);
        #2 n_reset = 1'b0;
        #1 chk("rst_req", "req_valid_async", req_valid_o, 0);
        cyc_begin(); n_reset = 1'b1; req_ready_i = 1'b1; cyc_sample();
        chk("rst_req", "req_valid_after", req_valid_o, 0);
        chk("rst_req", "stall_after", stall_o, 0);

        // Reset while waiting for the response; the late response must be dropped
        cyc_begin(); idle_inputs(); resp_valid_i = 1'b0; valid_i = 1'b1; is_load_i = 1'b1; alu_result_i = 32'h10; rd_addr_i = 5'd9; cyc_sample();
        cyc_begin(); idle_inputs(); resp_valid_i = 1'b0; req_ready_i = 1'b1; cyc_sample();
        chk("rst_wait", "req_valid", req_valid_o, 1);
        cyc_begin(); idle_inputs(); resp_valid_i = 1'b0; cyc_sample();
        chk("rst_wait", "stall_wait", stall_o, 1);
        #2 n_reset = 1'b0;
        #1 chk("rst_wait", "stall_async", stall_o, 0);
        cyc_begin(); n_reset = 1'b1; idle_inputs(); resp_valid_i = 1'b1; resp_data_i = 32'h1234_5678; cyc_sample();
        chk("rst_wait", "wb_after_resp", wb_valid_o, 0);
        cyc_begin(); idle_inputs(); resp_valid_i = 1'b0; cyc_sample();
        chk("rst_wait", "wb_late", wb_valid_o, 0);
        chk("rst_wait", "stall_idle", stall_o, 0);
        run_instr("rst_wait_alu", 0, 0, 0, 1, 5'd4, 32'h44, 32'h0, 0, 0, 32'h0, 4'hf, 32'h0, 32'h44);

        // Randomized traffic against a byte-addressed memory model
        for (int i = 0; i < 64; i++) ref_b[i] = 8'h0;
        for (int i = 0; i < 16; i++) dev_mem[i] = 32'h0;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 5);
            byt = 1'($urandom); rd = 5'($urandom); sd = $urandom; wbe = 1'($urandom);
            a = $urandom_range(0, 63);
            if (!byt) a = a & ~3;
            ld = 1'b0; st = 1'b0; eb = 4'hf; wd = 32'h0; exp_wb = 32'h0; rw = 32'h0;
            a32 = 32'(a);
            if (kind == 0) begin
                a32 = $urandom; exp_wb = a32;
            end else if (kind <= 2) begin
                ld = 1'b1;
                rw = dev_mem[a / 4];
                exp_wb = byt ? {24'h0, ref_b[a]} : {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
            end else if (kind <= 4) begin
                st = 1'b1; ld = 1'($urandom);
                if (byt) begin
                    eb = 4'(1 << (a % 4)); wd = {4{sd[7:0]}};
                end else begin
                    wd = sd;
                end
            end else begin
                ld = 1'($urandom); st = !ld; byt = 1'b0;
                a32 = 32'((a & ~3) + $urandom_range(1, 3));
            end
            run_instr($sformatf("rnd%0d", n), ld, st, byt, wbe, rd, a32, sd,
                      $urandom_range(0, 3), $urandom_range(0, 3), rw, eb, wd, exp_wb);
            if (kind >= 3 && kind <= 4) begin
                if (byt) ref_b[a] = sd[7:0];
                else for (int b = 0; b < 4; b++) ref_b[a+b] = sd[8*b +: 8];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the core, directly downstream of the ALU. Takes each executed instruction's ALU result (address or pass-through value) plus store data. Performs LW/LBU/SW/SB through a single-outstanding data-memory request/response handshake, and forwards non-memory results to writeback. Stalls the upstream pipeline while a memory access is in flight.

## Interface
- REG_ADDR_W, 5, width of destination register index
- clk  input  1  core clock, all state on rising edge
- n_reset  input  1  asynchronous, active-low reset
- valid_i  input  1  instruction from execute is present
- is_load_i  input  1  instruction is LW or LBU
- is_store_i  input  1  instruction is SW or SB
- is_byte_i  input  1  byte access (LBU/SB); ignored for non-memory ops
- wb_en_i  input  1  non-memory instruction writes a register
- rd_addr_i  input  REG_ADDR_W  destination register index
- alu_result_i  input  32  ALU result_o: memory address for loads/stores, write value otherwise
- store_data_i  input  32  store data
- stall_o  output  1  upstream must hold its outputs this cycle
- err_o  output  1  one-cycle pulse: misaligned word access dropped
- req_valid_o  output  1  memory request valid
- req_ready_i  input  1  memory accepts request
- req_we_o  output  1  1 = write, 0 = read
- req_addr_o  output  32  word-aligned address, bits [1:0] = 00
- req_be_o  output  4  byte enables
- req_wdata_o  output  32  write data
- resp_valid_i  input  1  read data valid
- resp_data_i  input  32  read word
- wb_valid_o  output  1  one-cycle pulse: write wb_data_o to wb_addr_o
- wb_addr_o  output  REG_ADDR_W  writeback register index
- wb_data_o  output  32  writeback value

## Operation
- FSM states: IDLE, REQ, WAIT. Reset -> IDLE.
- An instruction is accepted only when the FSM is in IDLE and valid_i = 1. In REQ and WAIT, inputs are ignored.
- Non-memory op (is_load_i = is_store_i = 0): stays in IDLE. If wb_en_i = 1, wb_valid_o = 1 next cycle with wb_data_o = alu_result_i and wb_addr_o = rd_addr_i.
- Memory op: the block latches the address, data, size, direction and rd_addr, then IDLE -> REQ.
  - Exception: a word access (is_byte_i = 0) with alu_result_i[1:0] != 00 is dropped. err_o pulses the next cycle, the FSM stays in IDLE and there is no writeback.
- REQ: req_valid_o = 1. Request fields are held stable until req_ready_i = 1.
  - On handshake, a store -> IDLE; a load -> WAIT.
- WAIT: on resp_valid_i = 1, wb_valid_o pulses the next cycle, then -> IDLE.
  - resp_valid_i outside WAIT is ignored.
- is_load_i and is_store_i both set: treated as a store.
- Byte lanes (a = addr[1:0]):
  - SB: req_be_o = 1 << a, req_wdata_o = {4{store_data[7:0]}}.
  - SW: req_be_o = 1111, req_wdata_o = store_data.
  - Loads: req_be_o = 1111.
  - LBU: wb_data_o = zero-extended resp_data_i[8a+7:8a].
  - LW: wb_data_o = resp_data_i.
- req_addr_o = {addr[31:2], 2'b00}.
- stall_o = (state != IDLE) | (state == IDLE & valid_i & (is_load_i | is_store_i) & !misaligned). This is combinational.

## Timing
- All outputs except stall_o are registered.
- Reset values: every output is 0, the FSM is in IDLE, and the latched request fields are 0.
- Assertion of n_reset mid-access immediately aborts the access: req_valid_o = 0, FSM to IDLE, and any pending writeback is lost.
- Non-memory op accepted in cycle T -> wb_valid_o in T+1. The block sustains one per cycle.
- Load accepted in T:
  - req_valid_o from T+1.
  - With req_ready_i in T+1 and resp_valid_i in T+2, wb_valid_o is in T+3.
  - stall_o is high in T, T+1 and T+2.
- Store accepted in T with req_ready_i in T+1: IDLE in T+2, and stall_o is high in T and T+1.
- Each additional cycle with req_ready_i = 0 or a missing response adds one cycle of stall.
- At most one memory access is outstanding.
- wb_valid_o and err_o are never high for more than one cycle per instruction.

## Test plan
- Reset: hold n_reset low with random inputs -> all outputs 0. Release -> the block accepts an ADDU result 0x0000_0005, wb_en_i = 1, rd 3 -> wb_valid_o 1 cycle later with data 5 and addr 3.
- LW at address 0x100, req_ready_i immediate, resp 0xDEAD_BEEF next cycle -> req_addr_o 0x100, be 1111, we 0; wb_data_o 0xDEAD_BEEF in T+3; stall_o high for exactly T..T+2.
- LBU at address 0x102, resp 0x1122_3344 -> wb_data_o 0x0000_0022. SB at 0x203 with data 0xAB -> req_addr_o 0x200, be 1000, wdata 0xABAB_ABAB, no writeback.
- Backpressure: req_ready_i low for 3 cycles -> request fields stable and stall_o held; a new valid_i during the stall is not accepted.
- LW at address 0x101 -> err_o pulse, no req_valid_o, no wb_valid_o, stall_o stays low.
- n_reset asserted in WAIT, then resp_valid_i arrives after release -> no wb_valid_o, FSM in IDLE.
